// File: rtl/serial_compare_accumulator_if.sv
// Handshake bundle between the 1-bit comparator stage and the serial accumulator.
// The master drives the per-bit codes. The slave returns the word-level result.
interface serial_compare_accumulator_if #(
  parameter int N  = 8,
  parameter int PW = $clog2(N)
);
  logic          start;
  logic          bit_valid;
  logic [2:0]    cmp_in;
  logic [2:0]    result;
  logic [PW-1:0] diff_pos;
  logic          busy;
  logic          done;
  logic          error;

  modport master (
    output start, bit_valid, cmp_in,
    input  result, diff_pos, busy, done, error
  );

  modport slave (
    input  start, bit_valid, cmp_in,
    output result, diff_pos, busy, done, error
  );
endinterface

// File: rtl/serial_compare_accumulator.sv
// Bit-serial magnitude comparator back end. It folds N one-hot per-bit codes,
// MSB first, into a word relation and records the index of the first differing bit.
module serial_compare_accumulator #(
  parameter int N  = 8,
  parameter int PW = $clog2(N)
) (
  input logic                          clk,
  input logic                          rst,
  serial_compare_accumulator_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] CODE_EQ = 3'b001;
  localparam logic [2:0] CODE_LT = 3'b010;
  localparam logic [2:0] CODE_GT = 3'b100;

  logic [1:0]    state;
  logic [PW-1:0] counter;
  logic [2:0]    rel_q;       // pending relation; non-zero means decided
  logic [2:0]    result_q;
  logic [PW-1:0] diff_pos_q;
  logic          error_q;
  logic          done_q;

  logic          legal;
  logic [2:0]    rel_nxt;
  logic [PW-1:0] pos_nxt;
  logic          err_nxt;
  logic [2:0]    res_fin;
  logic [PW-1:0] pos_fin;

  // Effect of accepting the current cmp_in. This is used only when a bit is taken in RUN.
  always_comb begin
    legal   = (bus.cmp_in == CODE_EQ) || (bus.cmp_in == CODE_LT) || (bus.cmp_in == CODE_GT);
    rel_nxt = rel_q;
    pos_nxt = diff_pos_q;
    err_nxt = error_q | ~legal;
    if (rel_q == 3'b000 && (bus.cmp_in == CODE_LT || bus.cmp_in == CODE_GT)) begin
      rel_nxt = bus.cmp_in;
      pos_nxt = counter;
    end
    res_fin = err_nxt ? 3'b000 : ((rel_nxt != 3'b000) ? rel_nxt : CODE_EQ);
    pos_fin = (err_nxt || rel_nxt == 3'b000) ? '0 : pos_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values. Reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      counter    <= '0;
      rel_q      <= 3'b000;
      result_q   <= 3'b000;
      diff_pos_q <= '0;
      error_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state      <= RUN;
            counter    <= PW'(N - 1);
            rel_q      <= 3'b000;
            result_q   <= 3'b000;
            diff_pos_q <= '0;
            error_q    <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (bus.bit_valid) begin
            rel_q   <= rel_nxt;
            error_q <= err_nxt;
            if (counter == '0) begin
              state      <= DONE;
              done_q     <= 1'b1;
              result_q   <= res_fin;
              diff_pos_q <= pos_fin;
            end else begin
              counter    <= counter - PW'(1);
              diff_pos_q <= pos_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result   = result_q;
  assign bus.diff_pos = diff_pos_q;
  assign bus.busy     = (state == RUN);
  assign bus.done     = done_q;
  assign bus.error    = error_q;

endmodule

// File: tb/tb_serial_compare_accumulator.sv
// Directed bench for serial_compare_accumulator (N=4). It uses a word-level reference model
// and a per-cycle output checker, plus literal expectations from hand-worked vectors.
module tb_serial_compare_accumulator;

  localparam int N  = 4;
  localparam int PW = $clog2(N);

  typedef enum {P_IDLE, P_RUN, P_DONE} phase_t;

  logic clk;
  logic rst;
  serial_compare_accumulator_if #(.N(N), .PW(PW)) bus ();

  serial_compare_accumulator #(.N(N), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model state
  phase_t     ph = P_IDLE;
  logic [2:0] acc[$];
  logic       m_busy, m_done, m_error;
  logic [2:0] m_result;
  int         m_pos;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Word-level view of the codes accepted so far (acc[0] is bit N-1).
  task automatic summarize(output logic err, output logic [2:0] rel, output int pos);
    err = 1'b0;
    rel = 3'b000;
    pos = 0;
    foreach (acc[k]) begin
      if (!(acc[k] inside {3'b001, 3'b010, 3'b100})) err = 1'b1;
      else if (rel == 3'b000 && acc[k] != 3'b001) begin
        rel = acc[k];
        pos = N - 1 - k;
      end
    end
  endtask

  task automatic model_step(input logic s, input logic v, input logic [2:0] c, input logic r);
    logic       err;
    logic [2:0] rel;
    int         pos;
    if (r) begin
      ph = P_IDLE; acc.delete();
      m_busy = 0; m_done = 0; m_result = 0; m_pos = 0; m_error = 0;
    end else begin
      case (ph)
        P_IDLE, P_DONE: begin
          m_done = 0;
          if (s) begin
            ph = P_RUN; acc.delete();
            m_busy = 1; m_result = 0; m_pos = 0; m_error = 0;
          end else begin
            ph = P_IDLE; m_busy = 0;
          end
        end
        P_RUN: if (v) begin
          acc.push_back(c);
          summarize(err, rel, pos);
          m_error = err;
          m_pos   = pos;
          if (acc.size() == N) begin
            ph = P_DONE; m_done = 1; m_busy = 0;
            m_result = err ? 3'b000 : ((rel != 3'b000) ? rel : 3'b001);
            m_pos    = (err || rel == 3'b000) ? 0 : pos;
          end
        end
        default: ph = P_IDLE;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",     32'(bus.busy),     32'(m_busy));
      check("done",     32'(bus.done),     32'(m_done));
      check("result",   32'(bus.result),   32'(m_result));
      check("diff_pos", 32'(bus.diff_pos), 32'(m_pos));
      check("error",    32'(bus.error),    32'(m_error));
    end
  end

  // One clock: drive the inputs, take the edge, advance the model, then step clear of the edge.
  task automatic cyc(input logic s, input logic v, input logic [2:0] c, input logic r);
    bus.start = s; bus.bit_valid = v; bus.cmp_in = c; rst = r;
    @(posedge clk);
    model_step(s, v, c, r);
    #1;
  endtask

  // Starts a comparison and feeds codes[N-1] down to codes[0]. Stalls stall_len cycles
  // before bit stall_before. Returns the edge count from the start edge to the first visible done.
  task automatic run_cmp(input logic [N-1:0][2:0] codes, input logic start_bv,
                         input int stall_before, input int stall_len, output int lat);
    int  n;
    bit  seen;
    n = 0; seen = 0; lat = -1;
    cyc(1'b1, start_bv, 3'b111, 1'b0); n++;
    for (int i = N - 1; i >= 0; i--) begin
      if (i == stall_before)
        for (int k = 0; k < stall_len; k++) begin
          cyc(1'b0, 1'b0, 3'b110, 1'b0); n++;
        end
      cyc(1'b0, 1'b1, codes[i], 1'b0); n++;
      if (!seen && bus.done) begin seen = 1; lat = n; end
    end
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc(1'b0, 1'b0, 3'b000, 1'b0); n++;
      if (bus.done) begin seen = 1; lat = n; end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    bus.start = 0; bus.bit_valid = 0; bus.cmp_in = 3'b000; rst = 1;
    cyc(0, 0, 3'b000, 1);
    chk_en = 1'b1;
    cyc(0, 0, 3'b000, 1);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_busy",   32'(bus.busy),   32'd0);
    cyc(0, 0, 3'b000, 0);
    cyc(0, 1, 3'b011, 0);   // bit_valid in IDLE is ignored
    cyc(0, 1, 3'b100, 0);

    // A=1010, B=1001
    run_cmp({3'b001, 3'b001, 3'b100, 3'b010}, 1'b0, -1, 0, lat);
    check("t1_lat",    32'(lat),          32'd5);
    check("t1_result", 32'(bus.result),   32'h4);
    check("t1_pos",    32'(bus.diff_pos), 32'd1);
    check("t1_error",  32'(bus.error),    32'd0);
    cyc(0, 0, 3'b000, 0);

    run_cmp({3'b001, 3'b001, 3'b001, 3'b001}, 1'b0, -1, 0, lat);
    check("eq_result", 32'(bus.result),   32'h1);
    check("eq_pos",    32'(bus.diff_pos), 32'd0);
    cyc(0, 0, 3'b000, 0);

    // Start and bit_valid together: the illegal code on the start cycle must not be taken.
    run_cmp({3'b010, 3'b100, 3'b100, 3'b001}, 1'b1, -1, 0, lat);
    check("msb_result", 32'(bus.result),   32'h2);
    check("msb_pos",    32'(bus.diff_pos), 32'd3);
    check("msb_error",  32'(bus.error),    32'd0);
    cyc(0, 0, 3'b000, 0);

    run_cmp({3'b001, 3'b001, 3'b001, 3'b010}, 1'b0, -1, 0, lat);
    check("lsb_result", 32'(bus.result),   32'h2);
    check("lsb_pos",    32'(bus.diff_pos), 32'd0);
    cyc(0, 0, 3'b000, 0);

    // Stall for three cycles between bits 2 and 1.
    run_cmp({3'b001, 3'b001, 3'b100, 3'b010}, 1'b0, 1, 3, lat);
    check("stall_lat",    32'(lat),          32'd8);
    check("stall_result", 32'(bus.result),   32'h4);
    check("stall_pos",    32'(bus.diff_pos), 32'd1);
    cyc(0, 0, 3'b000, 0);

    run_cmp({3'b001, 3'b011, 3'b001, 3'b001}, 1'b0, -1, 0, lat);
    check("ill_error",  32'(bus.error),    32'd1);
    check("ill_result", 32'(bus.result),   32'h0);
    check("ill_pos",    32'(bus.diff_pos), 32'd0);
    cyc(0, 0, 3'b000, 0);
    cyc(0, 0, 3'b000, 0);
    check("ill_hold", 32'(bus.error), 32'd1);
    cyc(1, 0, 3'b000, 0);
    check("ill_clear", 32'(bus.error), 32'd0);
    for (int i = 0; i < N; i++) cyc(0, 1, 3'b001, 0);
    check("ill_next_result", 32'(bus.result), 32'h1);

    // A decided relation followed by an illegal code still reports an error.
    cyc(0, 0, 3'b000, 0);
    run_cmp({3'b100, 3'b110, 3'b001, 3'b001}, 1'b0, -1, 0, lat);
    check("dec_ill_error",  32'(bus.error),  32'd1);
    check("dec_ill_result", 32'(bus.result), 32'h0);

    // Back to back, with a start pulsed in the middle of RUN.
    cyc(0, 0, 3'b000, 0);
    run_cmp({3'b001, 3'b100, 3'b001, 3'b001}, 1'b0, -1, 0, lat);
    check("b2b_first_result", 32'(bus.result), 32'h4);
    cyc(1, 0, 3'b000, 0);
    check("b2b_busy",    32'(bus.busy),   32'd1);
    check("b2b_cleared", 32'(bus.result), 32'h0);
    cyc(0, 1, 3'b001, 0);
    cyc(1, 1, 3'b001, 0);
    cyc(0, 1, 3'b010, 0);
    cyc(0, 1, 3'b100, 0);
    check("b2b_second_result", 32'(bus.result),   32'h2);
    check("b2b_second_pos",    32'(bus.diff_pos), 32'd1);
    cyc(0, 0, 3'b000, 0);

    // Reset after two of the four bits are accepted.
    cyc(1, 0, 3'b000, 0);
    cyc(0, 1, 3'b001, 0);
    cyc(0, 1, 3'b100, 0);
    cyc(0, 0, 3'b000, 1);
    check("mid_rst_busy",   32'(bus.busy),     32'd0);
    check("mid_rst_pos",    32'(bus.diff_pos), 32'd0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 3'b001, 0);
    run_cmp({3'b100, 3'b001, 3'b001, 3'b001}, 1'b0, -1, 0, lat);
    check("post_rst_lat",    32'(lat),          32'd5);
    check("post_rst_result", 32'(bus.result),   32'h4);
    check("post_rst_pos",    32'(bus.diff_pos), 32'd3);
    cyc(0, 0, 3'b000, 0);
    cyc(0, 0, 3'b000, 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
